lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer between the MEM stage and a variable-latency data memory port.
//  Accepts one access at a time (valid/ready) and drives a req/gnt/rvalid memory handshake.
//  Generates store byte enables and aligned store data.
//  Extracts and extends load data through load_extract, then returns a registered writeback result.
//  Stalls the pipeline while an access is outstanding; a watchdog ends hung reads.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in WAIT_RD without mem_rvalid before bus_err (>=2)
//  CNT_W           7   watchdog counter width, must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   access request from MEM stage
//  req_ready    out  1   controller can accept (state IDLE)
//  req_we       in   1   1=store, 0=load
//  req_sel      in   3   load: 000 LB,001 LH,010 LW,011 LBU,100 LHU; store: 000 SB,001 SH,010 SW
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-justified
//  req_rd       in   5   destination register of load
//  mem_req      out  1   memory request, held stable until mem_gnt
//  mem_gnt      in   1   memory accepts request this cycle
//  mem_we       out  1   write strobe qualifier
//  mem_addr     out  32  word address ({addr[31:2],2'b00})
//  mem_be       out  4   byte enables (stores), 4'b0000 for loads
//  mem_wdata    out  32  store data replicated into lanes
//  mem_rvalid   in   1   read data valid
//  mem_rdata    in   32  read word
//  ld_valid     out  1   1-cycle pulse: ld_data/ld_rd valid
//  ld_rd        out  5   destination register
//  ld_data      out  32  extracted, extended load result
//  stall        out  1   = ~req_ready | (state==IDLE & req_valid ? 0 : 0); i.e. state!=IDLE
//  bus_err      out  1   1-cycle pulse: watchdog timeout or trapped misalign
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; mem_req, mem_we, ld_valid, bus_err = 0; mem_be=0; counter=0;
//    addr/data regs=0. A transaction in flight is dropped; late mem_rvalid after reset is ignored in IDLE.
//  - FSM IDLE -> ISSUE on req_valid&req_ready (fields registered); ISSUE -> IDLE on mem_gnt if store;
//    ISSUE -> WAIT_RD on mem_gnt if load; WAIT_RD -> RESP on mem_rvalid; RESP -> IDLE (1 cycle).
//  - mem_req=1 only in ISSUE; mem_addr/mem_we/mem_be/mem_wdata constant throughout ISSUE.
//  - mem_rvalid is accepted only in WAIT_RD (earliest the cycle after gnt); ignored elsewhere.
//  - Latency: accept at N, mem_req at N+1, gnt at N+1 -> rvalid >= N+2 -> ld_valid at rvalid+1 (RESP).
//    Store with immediate gnt: req_ready again at N+2.
//  - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=addr[1]?1100:0011,
//    wdata={2{wdata[15:0]}}; SW be=1111; other sel -> be=0000 (no-op write still issued).
//  - Load extract: byte lane addr[1:0], half lane addr[1], sign/zero per sel; sel 101-111 -> 32'h0.
//  - Watchdog: counter clears on entering WAIT_RD and increments each WAIT_RD cycle; at TIMEOUT_CYCLES
//    -> bus_err pulse, ld_valid stays 0, state=IDLE. rvalid and timeout in the same cycle: rvalid wins.
//  - stall = (state!=IDLE). ld_valid and bus_err are never both 1.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, are accepted.
//    They never raise mem_req. The next cycle bus_err pulses, then the FSM returns to IDLE (state MISAL).
//  Not defined: no check. Low address bits are ignored per the lane rules above and the access is issued.
// STRUCTURE
//  lsu_pkg: state enum (IDLE,ISSUE,WAIT_RD,RESP,MISAL), LD_*/ST_* sel encodings, be lookup function.
//  Sub-module load_extract (combinational: sel, lane addr, rdata -> ld value); its output feeds the
//    ld_data register in lsu_mem_ctrl.
// TESTING
//  1 LB addr 0x103, rdata 0x80FF_0000, gnt immediate, rvalid 3 cycles later -> ld_data 0xFFFF_FF80,
//    single ld_valid, stall high until RESP.
//  2 SH addr 0x202, wdata 0x1234 -> mem_addr 0x200, be 1100, mem_wdata 0x1234_1234; gnt withheld 5 cycles
//    -> mem_req and all fields stable for those 5 cycles.
//  3 LHU addr 0x10, rdata 0xDEAD_BEEF -> 0x0000_BEEF; LW -> 0xDEAD_BEEF; sel 111 -> 0x0.
//  4 Load, no rvalid for TIMEOUT_CYCLES -> bus_err one pulse, no ld_valid, req_ready back next cycle.
//    Then rvalid exactly at the timeout cycle -> ld_valid, no bus_err.
//  5 rst_n low while in WAIT_RD -> mem_req/ld_valid 0 immediately; stray rvalid after release ignored.
//  6 With LSU_MISALIGN_TRAP_EN: LW addr 0x6 -> mem_req never asserted, bus_err one pulse.
//    Without the macro: the same access issues mem_addr 0x4.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
// Contents: FSM state enum, load/store size-select encodings, store lane helpers,
//           and the misalignment predicate used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    RESP    = 3'd3,
    MISAL   = 3'd4
  } state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [2:0] ST_SB  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SW  = 3'b010;

  // Byte enables for a store; unknown sizes produce an empty mask.
  function automatic logic [3:0] store_be(input logic [2:0] sel, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (sel)
      ST_SB:   be = 4'b0001 << lane;
      ST_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
      ST_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the LSB-justified store datum into every lane it could land in,
  // so the memory only needs the byte enables to pick the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] sel, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (sel)
      ST_SB:   d = {4{wdata[7:0]}};
      ST_SH:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(input logic we, input logic [2:0] sel, input logic [1:0] lane);
    logic m;
    m = 1'b0;
    if (we) begin
      case (sel)
        ST_SH:   m = lane[0];
        ST_SW:   m = |lane;
        default: m = 1'b0;
      endcase
    end else begin
      case (sel)
        LD_LH, LD_LHU: m = lane[0];
        LD_LW:         m = |lane;
        default:       m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational lane select and sign/zero extension of a read word.
// Ports: sel (load size/sign encoding), lane (addr[1:0]), rdata (memory word) -> data (result).
// Unsupported sel values return zero.
module load_extract
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (lane)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];

    data = 32'h0;
    case (sel)
      LD_LB:   data = {{24{byte_val[7]}}, byte_val};
      LD_LH:   data = {{16{half_val[15]}}, half_val};
      LD_LW:   data = rdata;
      LD_LBU:  data = {24'h0, byte_val};
      LD_LHU:  data = {16'h0, half_val};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time load/store sequencer between the MEM stage and a
// variable-latency data memory (req/gnt/rvalid). Stores get lane-replicated data and
// byte enables; loads return a registered, extended result one cycle after rvalid.
// Ports: req_* (MEM-stage request, valid/ready), mem_* (memory handshake),
//        ld_* (writeback pulse), stall (busy), bus_err (timeout / trapped misalign pulse).
// Config: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead
//         of issuing them with the low address bits ignored.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        bus_err
);
  import lsu_pkg::*;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        sel_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       ld_data_q;
  logic [31:0]       ext_data;
  logic              accept;
  logic              timeout;
  logic              misal_hit;

  assign accept = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_hit = misaligned(req_we, req_sel, req_addr[1:0]);
`else
  assign misal_hit = 1'b0;
`endif

  // Timeout fires on the TIMEOUT_CYCLES-th WAIT_RD cycle; an rvalid in that same
  // cycle takes priority and completes the load normally.
  assign timeout = (state == WAIT_RD) && !mem_rvalid &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misal_hit ? MISAL : ISSUE;
      ISSUE:   if (mem_gnt)   state_nxt = we_q ? IDLE : WAIT_RD;
      WAIT_RD: begin
        if (mem_rvalid)   state_nxt = RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      MISAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at accept so the memory sees stable values for
  // however long gnt is withheld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sel_q   <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      rd_q    <= 5'd0;
    end else if (accept) begin
      we_q    <= req_we;
      sel_q   <= req_sel;
      addr_q  <= req_addr;
      wdata_q <= req_we ? store_data(req_sel, req_wdata) : 32'h0;
      be_q    <= req_we ? store_be(req_sel, req_addr[1:0]) : 4'b0000;
      rd_q    <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state == ISSUE) && mem_gnt) begin
      cnt_q <= '0;
    end else if (state == WAIT_RD) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  load_extract u_load_extract (
    .sel   (sel_q),
    .lane  (addr_q[1:0]),
    .rdata (mem_rdata),
    .data  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data_q <= 32'h0;
    end else if ((state == WAIT_RD) && mem_rvalid) begin
      ld_data_q <= ext_data;
    end
  end

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign mem_req   = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ld_valid  = (state == RESP);
  assign ld_rd     = rd_q;
  assign ld_data   = ld_data_q;
  assign bus_err   = (state == MISAL) || timeout;

endmodule
